// File: rtl/bky_serial_loader.sv
`default_nettype none
// ============================================================================
//  Module   : bky_serial_loader
//  Purpose  : Word FIFO feeding an LSB-first serial shifter with readback.
//             Words are queued through WR_EN/WR_DATA. A START request shifts
//             the whole FIFO out on SCK/SDATA towards the one-hot selected
//             channel, capturing SDI into RB_DATA for every word sent.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    CLK40     in   1            system clock, rising edge
//    RST       in   1            asynchronous active-high reset
//    WR_EN     in   1            push WR_DATA into the FIFO
//    WR_DATA   in   DATA_W       word to queue
//    START     in   1            request to shift out the FIFO contents
//    CH_SEL    in   NCHAN        one-hot channel, latched on accepted START
//    ABORT     in   1            stop the transfer and flush the FIFO
//    CLR_DONE  in   1            clear the DONE and OVF flags
//    SDI       in   1            serial readback data
//    SCK       out  1            serial clock, idles low
//    SDATA     out  1            serial data, LSB first, idles low
//    CH_ENA    out  NCHAN        latched channel select while BUSY
//    BUSY      out  1            transfer in progress
//    DONE      out  1            sticky transfer-complete flag
//    OVF       out  1            sticky write-while-full flag
//    RB_DATA   out  DATA_W       last word captured from SDI
//    RB_VALID  out  1            one-cycle strobe when RB_DATA updates
//    WCOUNT    out  CNT_W        words currently held in the FIFO
// ============================================================================
module bky_serial_loader #(
    parameter int  DATA_W  = 16,
    parameter int  DEPTH   = 64,
    parameter int  SCK_DIV = 40,
    parameter int  NCHAN   = 6,
    localparam int CNT_W   = $clog2(DEPTH) + 1
) (
    input  logic              CLK40,
    input  logic              RST,
    input  logic              WR_EN,
    input  logic [DATA_W-1:0] WR_DATA,
    input  logic              START,
    input  logic [NCHAN-1:0]  CH_SEL,
    input  logic              ABORT,
    input  logic              CLR_DONE,
    input  logic              SDI,
    output logic              SCK,
    output logic              SDATA,
    output logic [NCHAN-1:0]  CH_ENA,
    output logic              BUSY,
    output logic              DONE,
    output logic              OVF,
    output logic [DATA_W-1:0] RB_DATA,
    output logic              RB_VALID,
    output logic [CNT_W-1:0]  WCOUNT
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int DIV_W = $clog2(SCK_DIV);
    localparam int BIT_W = $clog2(DATA_W);

    // Divider positions: the SCK rise happens on the edge that ends the low
    // half, the fall (and bit advance) on the edge that ends the high half.
    localparam logic [DIV_W-1:0] DIV_RISE = DIV_W'(SCK_DIV / 2 - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_SHIFT = 2'd2,
        S_FIN   = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t              state_q;
    logic [DATA_W-1:0]   shift_q;
    logic [DATA_W-1:0]   rb_shift_q;
    logic [DATA_W-1:0]   rb_data_q;
    logic [DIV_W-1:0]    div_q;
    logic [BIT_W-1:0]    bit_q;
    logic [NCHAN-1:0]    chan_q;
    logic                sck_q;
    logic                sdata_q;
    logic                busy_q;
    logic                done_q;
    logic                ovf_q;
    logic                rb_valid_q;

    logic [DATA_W-1:0]   mem_q [DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    count_q,  count_d;

    // ------------------------------------------------------------------
    // FIFO control
    // ------------------------------------------------------------------
    logic                fifo_full;
    logic                fifo_push;
    logic                fifo_pop;
    logic [DATA_W-1:0]   fifo_head;

    assign fifo_full = (count_q == CNT_FULL);
    // ABORT flushes the FIFO, so a write in the same cycle is discarded.
    assign fifo_push = WR_EN && !ABORT && !fifo_full;
    // LOAD is only entered with at least one word queued.
    assign fifo_pop  = (state_q == S_LOAD) && !ABORT;
    assign fifo_head = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (ABORT) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (fifo_push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (fifo_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (fifo_push && !fifo_pop) begin
                count_d = count_q + CNT_W'(1);
            end else if (fifo_pop && !fifo_push) begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge CLK40 or posedge RST) begin
        if (RST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage has no reset; the pointers define which entries are valid.
    always_ff @(posedge CLK40) begin
        if (fifo_push) begin
            mem_q[wr_ptr_q] <= WR_DATA;
        end
    end

    // ------------------------------------------------------------------
    // Transfer state machine with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge CLK40 or posedge RST) begin
        if (RST) begin
            state_q    <= S_IDLE;
            shift_q    <= '0;
            rb_shift_q <= '0;
            rb_data_q  <= '0;
            div_q      <= '0;
            bit_q      <= '0;
            chan_q     <= '0;
            sck_q      <= 1'b0;
            sdata_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
            rb_valid_q <= 1'b0;
        end else begin
            rb_valid_q <= 1'b0;

            // Clear first so that a coinciding set below takes precedence.
            if (CLR_DONE) begin
                done_q <= 1'b0;
                ovf_q  <= 1'b0;
            end
            if (WR_EN && !ABORT && fifo_full) begin
                ovf_q <= 1'b1;
            end

            if (ABORT) begin
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
                sck_q   <= 1'b0;
                sdata_q <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (START) begin
                            if (count_q != CNT_ZERO) begin
                                chan_q  <= CH_SEL;
                                busy_q  <= 1'b1;
                                state_q <= S_LOAD;
                            end else begin
                                state_q <= S_FIN;
                            end
                        end
                    end

                    S_LOAD: begin
                        shift_q <= fifo_head;
                        sdata_q <= fifo_head[0];
                        div_q   <= '0;
                        bit_q   <= '0;
                        sck_q   <= 1'b0;
                        state_q <= S_SHIFT;
                    end

                    S_SHIFT: begin
                        if (div_q == DIV_RISE) begin
                            // Rising SCK: capture SDI, MSB in, shift right.
                            sck_q      <= 1'b1;
                            rb_shift_q <= {SDI, rb_shift_q[DATA_W-1:1]};
                            div_q      <= div_q + DIV_W'(1);
                        end else if (div_q == DIV_LAST) begin
                            // Falling SCK: advance to the next data bit.
                            sck_q   <= 1'b0;
                            div_q   <= '0;
                            bit_q   <= bit_q + BIT_W'(1);
                            shift_q <= {1'b0, shift_q[DATA_W-1:1]};
                            sdata_q <= shift_q[1];
                            if (bit_q == BIT_LAST) begin
                                // Word finished; the readback capture is
                                // already complete since the last rise.
                                rb_data_q  <= rb_shift_q;
                                rb_valid_q <= 1'b1;
                                sdata_q    <= 1'b0;
                                if (count_q != CNT_ZERO) begin
                                    state_q <= S_LOAD;
                                end else begin
                                    busy_q  <= 1'b0;
                                    state_q <= S_FIN;
                                end
                            end
                        end else begin
                            div_q <= div_q + DIV_W'(1);
                        end
                    end

                    S_FIN: begin
                        done_q  <= 1'b1;
                        state_q <= S_IDLE;
                    end

                    default: begin
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign SCK      = sck_q;
    assign SDATA    = sdata_q;
    assign CH_ENA   = busy_q ? chan_q : '0;
    assign BUSY     = busy_q;
    assign DONE     = done_q;
    assign OVF      = ovf_q;
    assign RB_DATA  = rb_data_q;
    assign RB_VALID = rb_valid_q;
    assign WCOUNT   = count_q;

endmodule
`default_nettype wire

// File: tb/tb_bky_serial_loader.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_bky_serial_loader
//  Purpose  : Directed sequence with random data words for bky_serial_loader.
//             Expected serial streams, readback words and timing come from a
//             word-level model of the serial protocol.
//  Revision : 1.0  initial release
// ============================================================================
module tb_bky_serial_loader;

    localparam int DW    = 16;
    localparam int DEPTH = 16;
    localparam int DIV   = 40;
    localparam int NCH   = 6;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          CLK40    = 1'b0;
    logic          RST      = 1'b1;
    logic          WR_EN    = 1'b0;
    logic [DW-1:0] WR_DATA  = '0;
    logic          START    = 1'b0;
    logic [NCH-1:0] CH_SEL  = '0;
    logic          ABORT    = 1'b0;
    logic          CLR_DONE = 1'b0;
    logic          SDI;
    logic          SCK;
    logic          SDATA;
    logic [NCH-1:0] CH_ENA;
    logic          BUSY;
    logic          DONE;
    logic          OVF;
    logic [DW-1:0] RB_DATA;
    logic          RB_VALID;
    logic [CW-1:0] WCOUNT;

    bky_serial_loader #(
        .DATA_W  (DW),
        .DEPTH   (DEPTH),
        .SCK_DIV (DIV),
        .NCHAN   (NCH)
    ) u_dut (
        .CLK40    (CLK40),
        .RST      (RST),
        .WR_EN    (WR_EN),
        .WR_DATA  (WR_DATA),
        .START    (START),
        .CH_SEL   (CH_SEL),
        .ABORT    (ABORT),
        .CLR_DONE (CLR_DONE),
        .SDI      (SDI),
        .SCK      (SCK),
        .SDATA    (SDATA),
        .CH_ENA   (CH_ENA),
        .BUSY     (BUSY),
        .DONE     (DONE),
        .OVF      (OVF),
        .RB_DATA  (RB_DATA),
        .RB_VALID (RB_VALID),
        .WCOUNT   (WCOUNT)
    );

    always #5 CLK40 = ~CLK40;

    int cyc = 0;
    always @(posedge CLK40) cyc <= cyc + 1;

    int vectors    = 0;
    int miscompares = 0;

    // ------------------------------------------------------------------
    // Line monitor: records SCK rise times and the SDATA bit at each rise,
    // checks high-phase length, captures RB_DATA strobes, and loops SDI
    // back as the previously transmitted bit.
    // ------------------------------------------------------------------
    int            clr_req  = 0;
    int            clr_seen = 0;
    logic          sck_prev = 1'b0;
    logic          last_bit = 1'b0;
    int            hi_run   = 0;
    int            hi_err   = 0;
    int            rise_t[$];
    logic          bits_q[$];
    logic [DW-1:0] rb_q[$];

    initial SDI = 1'b0;

    always @(negedge CLK40) begin
        if (clr_req != clr_seen) begin
            clr_seen = clr_req;
            rise_t.delete();
            bits_q.delete();
            rb_q.delete();
            hi_err   = 0;
            hi_run   = 0;
            last_bit = 1'b0;
            SDI      = 1'b0;
        end
        if (SCK && !sck_prev) begin
            rise_t.push_back(cyc);
            bits_q.push_back(SDATA);
            last_bit = SDATA;
        end
        if (SCK) hi_run++;
        if (!SCK && sck_prev) begin
            if (hi_run != DIV / 2) hi_err++;
            hi_run = 0;
            SDI    = last_bit;
        end
        sck_prev = SCK;
        if (RB_VALID) rb_q.push_back(RB_DATA);
    end

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    task automatic tick(input int n = 1);
        repeat (n) @(negedge CLK40);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [DW-1:0] w);
        WR_EN   = 1'b1;
        WR_DATA = w;
        tick();
        WR_EN   = 1'b0;
    endtask

    task automatic clr_done();
        CLR_DONE = 1'b1;
        tick();
        CLR_DONE = 1'b0;
    endtask

    task automatic mon_clear();
        clr_req++;
        tick(2);
    endtask

    // Returns the clock-edge index at which START is sampled.
    task automatic do_start(input logic [NCH-1:0] ch, output int sc);
        START  = 1'b1;
        CH_SEL = ch;
        sc     = cyc + 1;
        tick();
        START  = 1'b0;
    endtask

    task automatic wait_done(input string tag, output int dc);
        int n = 0;
        while (!DONE && n < 4000) begin
            tick();
            n++;
        end
        check({tag, "_done_seen"}, 32'(DONE), 1);
        dc = cyc;
    endtask

    task automatic wait_rises(input string tag, input int n);
        int k = 0;
        while (rise_t.size() < n && k < 4000) begin
            tick();
            k++;
        end
        check({tag, "_rises_reached"}, 32'(rise_t.size() >= n), 1);
    endtask

    // Compare the captured serial stream against the words, LSB first.
    task automatic check_words(input string tag, input logic [DW-1:0] ws[$]);
        for (int k = 0; k < ws.size(); k++) begin
            logic [DW-1:0] obs = '0;
            for (int b = 0; b < DW; b++) begin
                if (k * DW + b < bits_q.size()) obs[b] = bits_q[k*DW+b];
            end
            check($sformatf("%s_word%0d", tag, k), 32'(obs), 32'(ws[k]));
        end
    endtask

    // SCK timing: first rise follows LOAD plus one low half; each bit lasts
    // DIV cycles, and a word boundary adds the single LOAD cycle.
    task automatic check_timing(input string tag, input int sc);
        int bad = 0;
        if (rise_t.size() > 0) check({tag, "_first_rise"}, 32'(rise_t[0] - sc), 1 + DIV / 2);
        for (int i = 1; i < rise_t.size(); i++) begin
            if (rise_t[i] - rise_t[i-1] != ((i % DW == 0) ? DIV + 1 : DIV)) bad++;
        end
        check({tag, "_period_errs"}, 32'(bad), 0);
        check({tag, "_high_len_errs"}, 32'(hi_err), 0);
    endtask

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    initial begin
        int            sc, sc2, dc;
        logic [DW-1:0] ws[$];
        logic          prev;

        // Reset state
        tick(3);
        check("rst_sck",    32'(SCK), 0);
        check("rst_sdata",  32'(SDATA), 0);
        check("rst_busy",   32'(BUSY), 0);
        check("rst_done",   32'(DONE), 0);
        check("rst_ovf",    32'(OVF), 0);
        check("rst_chena",  32'(CH_ENA), 0);
        check("rst_rbdata", 32'(RB_DATA), 0);
        check("rst_wcount", 32'(WCOUNT), 0);
        RST = 1'b0;
        tick(2);
        mon_clear();

        // Single known word
        push(16'hA5C3);
        do_start(6'b000100, sc);
        check("t1_busy",  32'(BUSY), 1);
        check("t1_chena", 32'(CH_ENA), 32'h04);
        wait_done("t1", dc);
        check("t1_done_latency", 32'(dc - sc), 1 + 16 * DIV + 1);
        check("t1_pulses", 32'(rise_t.size()), 16);
        ws = '{16'hA5C3};
        check_words("t1", ws);
        check_timing("t1", sc);
        check("t1_rb_count", 32'(rb_q.size()), 1);
        check("t1_busy_after", 32'(BUSY), 0);
        check("t1_chena_after", 32'(CH_ENA), 0);

        // Three random words, third pushed while the first is shifting
        clr_done();
        check("t2_done_cleared", 32'(DONE), 0);
        mon_clear();
        ws.delete();
        for (int i = 0; i < 3; i++) ws.push_back(DW'($urandom));
        push(ws[0]);
        push(ws[1]);
        do_start(6'b010001, sc);
        tick(100);
        push(ws[2]);
        check("t2_wcount_mid", 32'(WCOUNT), 2);
        wait_done("t2", dc);
        check("t2_done_latency", 32'(dc - sc), 3 * (1 + 16 * DIV) + 1);
        check("t2_pulses", 32'(rise_t.size()), 48);
        check_words("t2", ws);
        check_timing("t2", sc);
        check("t2_rb_count", 32'(rb_q.size()), 3);
        prev = 1'b0;
        for (int k = 0; k < 3 && k < rb_q.size(); k++) begin
            check($sformatf("t2_rb%0d", k), 32'(rb_q[k]), 32'({ws[k][DW-2:0], prev}));
            prev = ws[k][DW-1];
        end
        check("t2_rbdata_final", 32'(RB_DATA), 32'({ws[2][DW-2:0], ws[1][DW-1]}));

        // Overflow at 17 writes
        clr_done();
        for (int i = 0; i < 16; i++) push(DW'($urandom));
        check("t3_wcount_full", 32'(WCOUNT), 16);
        check("t3_ovf_at_full", 32'(OVF), 0);
        push(DW'($urandom));
        check("t3_wcount_after", 32'(WCOUNT), 16);
        check("t3_ovf_set", 32'(OVF), 1);
        clr_done();
        check("t3_ovf_cleared", 32'(OVF), 0);
        // ABORT wins over a write to a full FIFO
        ABORT   = 1'b1;
        WR_EN   = 1'b1;
        WR_DATA = DW'($urandom);
        tick();
        ABORT   = 1'b0;
        WR_EN   = 1'b0;
        check("t3_flush_wcount", 32'(WCOUNT), 0);
        check("t3_flush_no_ovf", 32'(OVF), 0);

        // Empty START, then START while busy
        mon_clear();
        do_start(6'b000001, sc);
        wait_done("t4e", dc);
        check("t4_empty_latency", 32'(dc - sc), 1);
        check("t4_empty_pulses", 32'(rise_t.size()), 0);
        clr_done();
        mon_clear();
        ws.delete();
        ws.push_back(DW'($urandom));
        push(ws[0]);
        do_start(6'b100000, sc);
        tick(50);
        do_start(6'b000011, sc2);
        tick();
        check("t4_chena_held", 32'(CH_ENA), 32'h20);
        wait_done("t4", dc);
        check("t4_done_latency", 32'(dc - sc), 1 + 16 * DIV + 1);
        check("t4_pulses", 32'(rise_t.size()), 16);
        check_words("t4", ws);

        // ABORT at bit 7 of word 2 out of 4
        clr_done();
        mon_clear();
        for (int i = 0; i < 4; i++) push(DW'($urandom));
        do_start(6'b001000, sc);
        wait_rises("t5", DW + 8);
        check("t5_sck_high_before", 32'(SCK), 1);
        ABORT = 1'b1;
        tick();
        ABORT = 1'b0;
        check("t5_sck",    32'(SCK), 0);
        check("t5_sdata",  32'(SDATA), 0);
        check("t5_chena",  32'(CH_ENA), 0);
        check("t5_busy",   32'(BUSY), 0);
        check("t5_wcount", 32'(WCOUNT), 0);
        tick(60);
        check("t5_no_done",  32'(DONE), 0);
        check("t5_rb_count", 32'(rb_q.size()), 1);
        check("t5_no_more_pulses", 32'(rise_t.size()), DW + 8);
        mon_clear();
        do_start(6'b000010, sc);
        wait_done("t5e", dc);
        check("t5_empty_latency", 32'(dc - sc), 1);
        check("t5_empty_pulses", 32'(rise_t.size()), 0);

        // Asynchronous reset mid-shift (DONE and OVF are set beforehand)
        for (int i = 0; i < 17; i++) push(DW'($urandom));
        do_start(6'b010000, sc);
        wait_rises("t6", 20);
        #2;
        RST = 1'b1;
        #1;
        check("t6_sck",      32'(SCK), 0);
        check("t6_sdata",    32'(SDATA), 0);
        check("t6_busy",     32'(BUSY), 0);
        check("t6_done",     32'(DONE), 0);
        check("t6_ovf",      32'(OVF), 0);
        check("t6_rbvalid",  32'(RB_VALID), 0);
        check("t6_chena",    32'(CH_ENA), 0);
        check("t6_rbdata",   32'(RB_DATA), 0);
        check("t6_wcount",   32'(WCOUNT), 0);
        tick(2);
        RST = 1'b0;
        tick(2);
        mon_clear();
        ws.delete();
        ws.push_back(DW'($urandom));
        push(ws[0]);
        do_start(6'b000001, sc);
        wait_done("t6r", dc);
        check("t6_resume_latency", 32'(dc - sc), 1 + 16 * DIV + 1);
        check("t6_resume_pulses", 32'(rise_t.size()), 16);
        check_words("t6r", ws);
        check_timing("t6r", sc);
        check("t6_resume_rb", 32'(RB_DATA), 32'({ws[0][DW-2:0], 1'b0}));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bky_serial_loader.md
BKY_SERIAL_LOADER -- requirements
Module: bky_serial_loader

Interface
REQ-001 Parameter DATA_W, default 16: serial word width in bits, range 2..32.
REQ-002 Parameter DEPTH, default 64: word FIFO depth, power of two, range 4..1024.
REQ-003 Parameter SCK_DIV, default 40: CLK40 cycles per serial bit, even, range 4..1024 (40 gives 1 MHz).
REQ-004 Parameter NCHAN, default 6: number of serial target channels, range 1..16.
REQ-005 CLK40  in  1  system clock; all logic is synchronous to its rising edge.
REQ-006 RST  in  1  reset, asynchronous, active-high.
REQ-007 WR_EN  in  1  push WR_DATA into FIFO.
REQ-008 WR_DATA  in  DATA_W  word to load.
REQ-009 START  in  1  one-cycle request to shift out the FIFO contents.
REQ-010 CH_SEL  in  NCHAN  one-hot target channel, sampled on accepted START.
REQ-011 ABORT  in  1  stop the transfer and flush the FIFO.
REQ-012 CLR_DONE  in  1  clear DONE and OVF.
REQ-013 SDI  in  1  serial readback data from target.
REQ-014 SCK  out  1  serial clock.
REQ-015 SDATA  out  1  serial data, LSB first.
REQ-016 CH_ENA  out  NCHAN  per-channel enable, equal to the latched CH_SEL while BUSY, else 0.
REQ-017 BUSY  out  1  transfer in progress.
REQ-018 DONE  out  1  sticky, transfer completed.
REQ-019 OVF  out  1  sticky, write attempted while FIFO full.
REQ-020 RB_DATA  out  DATA_W  last word captured from SDI.
REQ-021 RB_VALID  out  1  one-cycle strobe when RB_DATA updates.
REQ-022 WCOUNT  out  clog2(DEPTH)+1  words currently in FIFO.

Function
REQ-023 FIFO: synchronous single-clock; WR_EN with FIFO not full stores the word; WR_EN when full drops the word and sets OVF. A simultaneous push and pop are both performed and WCOUNT is unchanged.
REQ-024 FSM states: IDLE, LOAD, SHIFT, FIN.
REQ-025 IDLE: START with WCOUNT>0 latches CH_SEL and enters LOAD; START with WCOUNT=0 enters FIN with no SCK pulses; BUSY=0.
REQ-026 LOAD (one cycle): pop the FIFO head into the shift register, clear the bit counter and divider, enter SHIFT; BUSY=1 from this cycle.
REQ-027 SHIFT: SDATA=shift[0]; SCK low for the first SCK_DIV/2 cycles of each bit and high for the second SCK_DIV/2.
REQ-028 On the SCK rising transition, sample SDI into the readback register (MSB in, shift right).
REQ-029 On the SCK falling transition, shift the data register right by one (zero fill) and increment the bit counter.
REQ-030 After bit DATA_W-1 falls: RB_DATA is updated and RB_VALID pulses for one cycle. Then go to LOAD if WCOUNT>0, else to FIN. Consecutive words have no gap beyond the one LOAD cycle.
REQ-031 FIN (one cycle): set DONE, drive BUSY=0, return to IDLE.
REQ-032 START while BUSY is ignored; CH_SEL changes while BUSY are ignored.
REQ-033 WR_EN while BUSY is allowed; words pushed before the current word ends are sent in the same transfer.
REQ-034 ABORT in any state: next cycle enter IDLE, SCK=0, SDATA=0, CH_ENA=0, FIFO emptied, DONE not set, no RB_VALID. ABORT has priority over START and WR_EN in the same cycle.
REQ-035 CLR_DONE clears DONE and OVF; when coincident with a set event, the set wins.
REQ-036 SCK idles low and SDATA idles 0 outside SHIFT.

Reset
REQ-037 RST forces IDLE and an empty FIFO. SCK, SDATA, BUSY, DONE, OVF, RB_VALID and CH_ENA are 0, RB_DATA is 0 and WCOUNT is 0, regardless of state mid-transfer.

Verification (DATA_W=16, SCK_DIV=40, DEPTH=16, NCHAN=6)
REQ-038 Push 16'hA5C3, then START with CH_SEL=6'b000100 -> CH_ENA=6'b000100. 16 SCK pulses, each 20 cycles low and 20 cycles high. SDATA bits are 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1. DONE=1 exactly 1+640+1 cycles after START.
REQ-039 Push 3 words, then START -> 48 SCK pulses with a single-cycle LOAD between words. RB_VALID pulses 3 times. SDI tied to SDATA of the previous bit gives the expected RB_DATA values.
REQ-040 Push 17 words into an empty FIFO -> WCOUNT=16 and OVF=1. CLR_DONE -> OVF=0.
REQ-041 START with an empty FIFO -> DONE one cycle later with zero SCK pulses. START while BUSY does not change the pulse count.
REQ-042 ABORT at bit 7 of word 2 of 4 -> SCK low the next cycle, WCOUNT=0, DONE stays 0, and the following START sets DONE with no pulses.
REQ-043 RST asserted mid-SHIFT -> all outputs 0 immediately (asynchronous). Normal operation resumes after RST is released.
